// File: rtl/div_fpu.sv
//------------------------------------------------------------------------------
// div_fpu : iterative binary32 divider, restoring radix-2, RNE, denormals flushed
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic [31:0] result,
  output logic        busy,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    DIVIDE = 2'd2,
    ROUND  = 2'd3
  } state_t;

  state_t             state;
  logic [31:0]        op_a, op_b;
  logic               sign;
  logic signed [9:0]  exp_q;
  logic [24:0]        rem;
  logic [23:0]        divisor;
  logic [25:0]        quo;
  logic [4:0]         cnt;
  logic               special, special_dbz;
  logic [31:0]        special_val;

  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic [23:0]        ma, mb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic signed [9:0]  e_raw;
  logic               sp, sp_dbz;
  logic [31:0]        sp_val;

  always_comb begin
    ea     = op_a[30:23];
    eb     = op_b[30:23];
    fa     = op_a[22:0];
    fb     = op_b[22:0];
    ma     = {|ea, fa};
    mb     = {|eb, fb};
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    sgn    = op_a[31] ^ op_b[31];
    e_raw  = signed'({2'b00, ea}) - signed'({2'b00, eb}) + 10'sd127;
    sp     = 1'b1;
    sp_dbz = 1'b0;
    sp_val = 32'h7FC0_0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_val = 32'h7FC0_0000;
    end else if (a_inf) begin
      sp_val = {sgn, 8'hFF, 23'd0};
    end else if (b_zero) begin
      sp_val = {sgn, 8'hFF, 23'd0};
      sp_dbz = 1'b1;
    end else if (b_inf || a_zero) begin
      sp_val = {sgn, 31'd0};
    end else begin
      sp = 1'b0;
    end
  end

  logic [25:0] diff;
  logic        borrow;
  logic [24:0] rem_next;

  always_comb begin
    diff     = {1'b0, rem} - {2'b00, divisor};
    borrow   = diff[25];
    rem_next = borrow ? {rem[23:0], 1'b0} : {diff[23:0], 1'b0};
  end

  // quo[25] integer bit, quo[24:2] fraction, quo[1] guard, quo[0] round
  logic              inc;
  logic [24:0]       mant;
  logic signed [9:0] e_fin;
  logic [31:0]       rnd_val;

  always_comb begin
    inc   = quo[1] & (quo[0] | (rem != 25'd0) | quo[2]);
    mant  = {1'b0, quo[25:2]} + {24'd0, inc};
    e_fin = mant[24] ? exp_q + 10'sd1 : exp_q;
    if (e_fin >= 10'sd255) begin
      rnd_val = {sign, 8'hFF, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      rnd_val = {sign, 31'd0};
    end else begin
      rnd_val = {sign, e_fin[7:0], mant[24] ? 23'd0 : mant[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b0;
      busy        <= 1'b0;
      result      <= 32'd0;
      div_by_zero <= 1'b0;
      cnt         <= 5'd0;
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      sign        <= 1'b0;
      exp_q       <= 10'sd0;
      rem         <= 25'd0;
      divisor     <= 24'd0;
      quo         <= 26'd0;
      special     <= 1'b0;
      special_dbz <= 1'b0;
      special_val <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          busy  <= start;
          if (start) begin
            op_a        <= a;
            op_b        <= b;
            div_by_zero <= 1'b0;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          sign        <= sgn;
          divisor     <= mb;
          // pre-normalise so the quotient lands in [1,2)
          exp_q       <= (ma < mb) ? e_raw - 10'sd1 : e_raw;
          rem         <= (ma < mb) ? {ma, 1'b0} : {1'b0, ma};
          quo         <= 26'd0;
          cnt         <= 5'd0;
          special     <= sp;
          special_dbz <= sp_dbz;
          special_val <= sp_val;
          state       <= DIVIDE;
        end
        DIVIDE: begin
          rem <= rem_next;
          quo <= {quo[24:0], ~borrow};
          if (cnt == 5'd25) begin
            cnt   <= 5'd0;
            state <= ROUND;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ROUND: begin
          result      <= special ? special_val : rnd_val;
          div_by_zero <= special & special_dbz;
          ready       <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
